// File: rtl/zx8x_pkg.sv
// Shared types and constants for the ZX80/ZX81 video-buffer write path.
package zx8x_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int          CHARSET_SIZE   = 512;
    localparam logic [12:0] DFILE_BUF_BASE = 13'h400;
    localparam logic [7:0]  HALT_CHAR      = 8'h76;
    localparam logic [7:0]  BLANK_GLYPH    = 8'h00;

    // One pending buffer write: 13-bit buffer address plus data byte.
    typedef struct packed {
        logic [12:0] addr;
        logic [7:0]  data;
    } wr_entry_t;

endpackage

// File: rtl/zx8x_wr_fifo.sv
// Small synchronous FIFO for pending buffer writes.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// A push into a full FIFO is taken when a pop happens in the same cycle: the
// head is read combinationally before the slot is overwritten at the edge.
module zx8x_wr_fifo
    import zx8x_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk50m,
    input  logic                     reset,
    input  logic                     push,
    input  wr_entry_t                push_data,
    input  logic                     pop,
    output wr_entry_t                pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    LVL_FULL = DEPTH[AW:0];

    wr_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Qualify requests against the current occupancy.
    always_comb begin
        empty    = (level == '0);
        full     = (level == LVL_FULL);
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        pop_data = mem[rd_ptr];
    end

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk50m) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves level unchanged.
    always_ff @(posedge clk50m) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/zx8x_vram_writer.sv
// Write side of the ZX8x video buffer: snoops CPU writes into the charset and
// display-file windows, queues them, and replays them as single-cycle strobes
// on the buffer write port. After reset or on clear_req, sweeps the buffer to
// a blank charset and an all-HALT display file.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | drain queued CPU writes; start a pending sweep once drained
//   CLEAR | blanking sweep, one buffer write per cycle from cnt
module zx8x_vram_writer
    import zx8x_pkg::*;
#(
    parameter logic [15:0] CHARSET_BASE = 16'h2C00,
    parameter logic [15:0] DFILE_BASE   = 16'h2400,
    parameter int          DFILE_LEN    = 1024,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic         clk50m,
    input  logic         reset,
    input  logic [15:0]  cpu_addr,
    input  logic [7:0]   cpu_data,
    input  logic         cpu_wr,
    input  logic         clear_req,
    output logic [7:0]   buf_write,
    output logic [12:0]  buf_write_addr,
    output logic         buf_we,
    output logic         busy,
    output logic         overflow
);

    localparam int          LW         = $clog2(FIFO_DEPTH) + 1;
    localparam int          SWEEP_LEN  = CHARSET_SIZE + DFILE_LEN;
    localparam logic [10:0] SWEEP_LAST = 11'(SWEEP_LEN - 1);
    localparam logic [10:0] CS_CNT     = 11'(CHARSET_SIZE);
    localparam logic [16:0] CS_LO      = {1'b0, CHARSET_BASE};
    localparam logic [16:0] CS_HI      = CS_LO + 17'(CHARSET_SIZE);
    localparam logic [16:0] DF_LO      = {1'b0, DFILE_BASE};
    localparam logic [16:0] DF_HI      = DF_LO + 17'(DFILE_LEN);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);

    state_t          state;
    logic [10:0]     cnt;
    logic            clear_pend;
    logic            wr_prev;

    logic            cap;
    logic            in_cs;
    logic            in_df;
    logic            cap_hit;
    logic [16:0]     addr_ext;
    logic [12:0]     cs_off;
    logic [12:0]     df_off;
    wr_entry_t       cap_entry;

    logic            pop;
    logic            push_ok;
    logic            drop;
    logic            go_clear;
    logic            clear_pend_nxt;
    logic            fifo_busy_nxt;
    logic            busy_nxt;
    logic [12:0]     sweep_addr;
    logic [7:0]      sweep_data;

    wr_entry_t       fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [LW-1:0]   fifo_level;

    // Previous cpu_wr for edge detection; tracks the bus during reset too so a
    // strobe held across reset is not captured a second time.
    always_ff @(posedge clk50m) begin
        wr_prev <= cpu_wr;
    end

    // Capture edge and window decode. The low 13 bits of a 16-bit difference
    // equal the difference of the low 13 bits, so only those are computed.
    always_comb begin
        cap      = cpu_wr & ~wr_prev;
        addr_ext = {1'b0, cpu_addr};
        in_cs    = (addr_ext >= CS_LO) && (addr_ext < CS_HI);
        in_df    = (addr_ext >= DF_LO) && (addr_ext < DF_HI);
        cs_off   = cpu_addr[12:0] - CHARSET_BASE[12:0];
        df_off   = cpu_addr[12:0] - DFILE_BASE[12:0];
        cap_hit  = cap & (in_cs | in_df);
        cap_entry.data = cpu_data;
        cap_entry.addr = in_cs ? cs_off : (DFILE_BUF_BASE + df_off);
    end

    // Queue control, sweep address generation and next-cycle busy.
    always_comb begin
        pop      = (state == IDLE) & ~fifo_empty;
        push_ok  = cap_hit & (~fifo_full | pop);
        drop     = cap_hit & ~push_ok;
        go_clear = (state == IDLE) & fifo_empty & clear_pend;

        // A request arriving while one is already pending merges into it.
        clear_pend_nxt = go_clear ? 1'b0 : (clear_pend | (clear_req & (state != CLEAR)));

        fifo_busy_nxt = push_ok
                      | (fifo_level > LVL_ONE)
                      | ((fifo_level == LVL_ONE) & ~pop);

        // Current CLEAR and an in-flight pop keep busy up through the cycle
        // that shows the final strobe.
        busy_nxt = (state == CLEAR) | pop | go_clear | clear_pend_nxt | fifo_busy_nxt;

        if (cnt < CS_CNT) begin
            sweep_addr = {2'b00, cnt};
            sweep_data = BLANK_GLYPH;
        end else begin
            sweep_addr = DFILE_BUF_BASE + {2'b00, cnt - CS_CNT};
            sweep_data = HALT_CHAR;
        end
    end

    zx8x_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk50m    (clk50m),
        .reset     (reset),
        .push      (push_ok),
        .push_data (cap_entry),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Sequencer: replays queued writes in IDLE, runs the blanking sweep in CLEAR.
    always_ff @(posedge clk50m) begin
        if (reset) begin
            state          <= CLEAR;
            cnt            <= '0;
            clear_pend     <= 1'b0;
            overflow       <= 1'b0;
            buf_we         <= 1'b0;
            buf_write      <= '0;
            buf_write_addr <= '0;
            busy           <= 1'b1;
        end else begin
            buf_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        buf_we         <= 1'b1;
                        buf_write      <= fifo_head.data;
                        buf_write_addr <= fifo_head.addr;
                    end else if (go_clear) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    buf_we         <= 1'b1;
                    buf_write      <= sweep_data;
                    buf_write_addr <= sweep_addr;
                    if (cnt == SWEEP_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            clear_pend <= clear_pend_nxt;

            // A drop in the same cycle as clear_req wins: it is a newer event.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_req) begin
                overflow <= 1'b0;
            end

            busy <= busy_nxt;
        end
    end

endmodule
